// File: rtl/fnd_scan.sv
// Eight-digit multiplexed 7-segment scan driver with shadow/active double buffering.
// Optional leading-zero blanking is enabled by defining FND_LZ_BLANK_EN.
module fnd_scan #(
  parameter int unsigned SCAN_DIV  = 2048,
  parameter int unsigned BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_mask,
  input  logic        load,
  output logic [7:0]  fnd_row,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int unsigned MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic             wrap_c;
  logic [31:0]      shadow_digits, act_digits;
  logic [7:0]       shadow_dp, act_dp;
  logic [7:0]       row_nxt, seg_nxt;
  logic [3:0]       cur_digit_c;
  logic [6:0]       seg_dec_c;
  logic [7:0]       lz_blank_c;

  // Hex to {A..G} segment decode
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    case (d)
      4'h0: hex_to_seg = 7'b1111110;
      4'h1: hex_to_seg = 7'b0110000;
      4'h2: hex_to_seg = 7'b1101101;
      4'h3: hex_to_seg = 7'b1111001;
      4'h4: hex_to_seg = 7'b0110011;
      4'h5: hex_to_seg = 7'b1011011;
      4'h6: hex_to_seg = 7'b1011111;
      4'h7: hex_to_seg = 7'b1110000;
      4'h8: hex_to_seg = 7'b1111111;
      4'h9: hex_to_seg = 7'b1111011;
      4'hA: hex_to_seg = 7'b1110111;
      4'hB: hex_to_seg = 7'b0011111;
      4'hC: hex_to_seg = 7'b1001110;
      4'hD: hex_to_seg = 7'b0111101;
      4'hE: hex_to_seg = 7'b1001111;
      default: hex_to_seg = 7'b1000111;
    endcase
  endfunction

  assign cur_digit_c = act_digits[{idx, 2'b00} +: 4];
  assign seg_dec_c   = hex_to_seg(cur_digit_c);

`ifdef FND_LZ_BLANK_EN
  // Digit n blanks while it and every more-significant digit are zero; digit 0 always shows
  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    lz_blank_c = '0;
    for (int n = 7; n >= 1; n--) begin
      all_zero      = all_zero & (act_digits[4*n +: 4] == 4'h0);
      lz_blank_c[n] = all_zero;
    end
  end
`else
  assign lz_blank_c = '0;
`endif

  // Next-state logic and pre-register output values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    idx_nxt   = idx;
    wrap_c    = 1'b0;
    row_nxt   = '0;
    seg_nxt   = '0;
    case (state)
      ST_BLANK: begin
        if (cnt == CNT_W'(BLANK_CYC - 1)) begin
          state_nxt = ST_DRIVE;
          cnt_nxt   = '0;
        end
      end
      ST_DRIVE: begin
        row_nxt = 8'(1) << idx;
        seg_nxt = {(lz_blank_c[idx] ? 7'b0 : seg_dec_c), act_dp[idx]};
        if (cnt == CNT_W'(SCAN_DIV - 1)) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          idx_nxt   = idx + 3'd1;
          wrap_c    = (idx == 3'd7);
        end
      end
      default: state_nxt = ST_BLANK;
    endcase
  end

  // State, registered outputs and buffers; the copy uses the pre-load shadow value
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_BLANK;
      cnt           <= '0;
      idx           <= '0;
      fnd_row       <= '0;
      seg           <= '0;
      frame_done    <= 1'b0;
      shadow_digits <= '0;
      shadow_dp     <= '0;
      act_digits    <= '0;
      act_dp        <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      fnd_row    <= row_nxt;
      seg        <= seg_nxt;
      frame_done <= wrap_c;
      if (load) begin
        shadow_digits <= digits;
        shadow_dp     <= dp_mask;
      end
      if (frame_done) begin
        act_digits <= shadow_digits;
        act_dp     <= shadow_dp;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan.sv
// Directed bench for fnd_scan at SCAN_DIV=4, BLANK_CYC=2 (48-cycle frames).
// Honours FND_LZ_BLANK_EN in its expected-value model.
module tb_fnd_scan;

  logic        clk;
  logic        rst;
  logic [31:0] digits;
  logic [7:0]  dp_mask;
  logic        load;
  logic [7:0]  fnd_row;
  logic [7:0]  seg;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [7:0] SEG_TAB [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  fnd_scan #(.SCAN_DIV(4), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .load       (load),
    .fnd_row    (fnd_row),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_seg(input logic [31:0] d, input logic [7:0] dp, input int k);
    logic [3:0] dig;
    logic       blank;
    dig   = d[4*k +: 4];
    blank = 1'b0;
`ifdef FND_LZ_BLANK_EN
    blank = (k >= 1);
    for (int m = k; m < 8; m++)
      if (d[4*m +: 4] != 4'h0) blank = 1'b0;
`endif
    model_seg = (blank ? 8'h00 : SEG_TAB[dig]) | {7'b0, dp[k]};
  endfunction

  // Observes one 48-cycle frame starting at a frame-boundary negedge, optionally issuing loads
  task automatic scan_frame(input logic [31:0] show_d, input logic [7:0] show_dp,
                            input int ld_at, input int ld_n,
                            input logic [31:0] ld_d0, input logic [31:0] ld_d1,
                            input logic [7:0] ld_dp);
    logic [7:0] e_row, e_seg;
    logic       e_fd;
    int         p;
    for (int j = 0; j <= 48; j++) begin
      if (j > 0) begin
        @(negedge clk);
        p     = j - 3;
        e_row = 8'h00;
        e_seg = 8'h00;
        if (p >= 0 && (p % 6) < 4) begin
          e_row = 8'(1) << (p / 6);
          e_seg = model_seg(show_d, show_dp, p / 6);
        end
        e_fd = (j == 48);
        n_checks++;
        if (fnd_row !== e_row) $display("FAIL scan_row j=%0d: got %h want %h", j, fnd_row, e_row);
        else n_pass++;
        n_checks++;
        if (seg !== e_seg) $display("FAIL scan_seg j=%0d: got %h want %h", j, seg, e_seg);
        else n_pass++;
        n_checks++;
        if (frame_done !== e_fd) $display("FAIL scan_frame_done j=%0d: got %b want %b", j, frame_done, e_fd);
        else n_pass++;
      end
      if (j < 48) begin
        load = 1'b0;
        if (ld_n > 0 && j >= ld_at && j < ld_at + ld_n) begin
          load    = 1'b1;
          digits  = (j == ld_at) ? ld_d0 : ld_d1;
          dp_mask = ld_dp;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; digits = '0; dp_mask = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (fnd_row !== 8'h00) $display("FAIL reset_row: got %h want 00", fnd_row); else n_pass++;
    n_checks++;
    if (seg !== 8'h00) $display("FAIL reset_seg: got %h want 00", seg); else n_pass++;
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else n_pass++;
  endtask

  task automatic test_idle_scan();
    scan_frame(32'h0, 8'h00, -1, 0, 32'h0, 32'h0, 8'h00);
  endtask

  task automatic test_load_midframe();
    scan_frame(32'h0, 8'h00, 20, 1, 32'h76543210, 32'h0, 8'h01);
    scan_frame(32'h76543210, 8'h01, -1, 0, 32'h0, 32'h0, 8'h00);
  endtask

  task automatic test_load_wrap();
    scan_frame(32'h76543210, 8'h01, 0, 1, 32'h89ABCDEF, 32'h0, 8'hF0);
    scan_frame(32'h89ABCDEF, 8'hF0, -1, 0, 32'h0, 32'h0, 8'h00);
  endtask

  task automatic test_back_to_back();
    scan_frame(32'h89ABCDEF, 8'hF0, 10, 2, 32'h11111111, 32'h22222222, 8'h00);
    scan_frame(32'h22222222, 8'h00, -1, 0, 32'h0, 32'h0, 8'h00);
  endtask

  task automatic test_lz_pattern();
    scan_frame(32'h22222222, 8'h00, 5, 1, 32'h00000305, 32'h0, 8'h80);
    scan_frame(32'h00000305, 8'h80, -1, 0, 32'h0, 32'h0, 8'h00);
  endtask

  task automatic test_reset_mid();
    logic [7:0] e_seg;
    repeat (21) @(negedge clk);
    e_seg = model_seg(32'h00000305, 8'h80, 3);
    n_checks++;
    if (fnd_row !== 8'h08) $display("FAIL midrst_pre_row: got %h want 08", fnd_row); else n_pass++;
    n_checks++;
    if (seg !== e_seg) $display("FAIL midrst_pre_seg: got %h want %h", seg, e_seg); else n_pass++;
    load = 1'b1; digits = 32'h12345678; dp_mask = 8'hFF;
    @(negedge clk);
    load = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (fnd_row !== 8'h00) $display("FAIL midrst_row: got %h want 00", fnd_row); else n_pass++;
    n_checks++;
    if (seg !== 8'h00) $display("FAIL midrst_seg: got %h want 00", seg); else n_pass++;
    scan_frame(32'h0, 8'h00, -1, 0, 32'h0, 32'h0, 8'h00);
    scan_frame(32'h0, 8'h00, -1, 0, 32'h0, 32'h0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load_midframe();
    test_load_wrap();
    test_back_to_back();
    test_lz_pattern();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
